// File: rtl/regfile_pkg.sv
// Shared widths, state encoding and read-path helper for the 16x16 register file.
package regfile_pkg;

  localparam int REG_W     = 16;
  localparam int REG_CNT   = 16;
  localparam int REG_IDX_W = 4;

  typedef logic [REG_W-1:0]     reg_word_t;
  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef enum logic {
    CLEAR,
    RUN
  } regfile_state_t;

  // Read data priority: clearing forces zero, then hard-wired r0, then
  // same-cycle write bypass, then stored contents.
  function automatic reg_word_t select_read(
    input logic      clearing,
    input logic      is_zero_reg,
    input logic      bypass,
    input reg_word_t wdata,
    input reg_word_t stored
  );
    reg_word_t result;
    if (clearing || is_zero_reg) begin
      result = '0;
    end else if (bypass) begin
      result = wdata;
    end else begin
      result = stored;
    end
    return result;
  endfunction

endpackage

// File: rtl/regfile.sv
// Two-read / one-write register file with registered read ports, write
// bypass, optional hard-wired r0 and a post-reset clear sequencer.
module regfile
  import regfile_pkg::*;
#(
  parameter bit R0_ZERO        = 1'b1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                 cpu_clk,
  input  logic                 cpu_rst,
  input  logic                 reg_a_read,
  input  logic [REG_IDX_W-1:0] reg_a,
  input  logic                 reg_b_read,
  input  logic [REG_IDX_W-1:0] reg_b,
  output logic [REG_W-1:0]     reg_a_value,
  output logic [REG_W-1:0]     reg_b_value,
  input  logic                 wr_en,
  input  logic [REG_IDX_W-1:0] wr_reg,
  input  logic [REG_W-1:0]     wr_value,
  output logic                 busy
);

  reg_word_t      mem_q [REG_CNT];
  regfile_state_t state_q, state_d;
  reg_idx_t       cnt_q, cnt_d;
  reg_word_t      a_q, a_d;
  reg_word_t      b_q, b_d;

  logic      clearing;
  logic      ext_we;
  logic      mem_we;
  reg_idx_t  mem_waddr;
  reg_word_t mem_wdata;

  assign clearing = (state_q == CLEAR);
  assign ext_we   = wr_en && !clearing && !(R0_ZERO && (wr_reg == '0));

  // Sequencer: one index per cycle, parks on the last index and leaves CLEAR.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (clearing) begin
      if (cnt_q == reg_idx_t'(REG_CNT - 1)) begin
        state_d = RUN;
      end else begin
        cnt_d = cnt_q + reg_idx_t'(1);
      end
    end
  end

  // Single write port shared by the sequencer and write-back.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_reg;
    mem_wdata = wr_value;
    if (cpu_rst) begin
      if (clearing) begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = '0;
      end else if (ext_we) begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (reg_a_read) begin
      a_d = select_read(clearing, R0_ZERO && (reg_a == '0),
                        ext_we && (wr_reg == reg_a), wr_value, mem_q[reg_a]);
    end
    if (reg_b_read) begin
      b_d = select_read(clearing, R0_ZERO && (reg_b == '0),
                        ext_we && (wr_reg == reg_b), wr_value, mem_q[reg_b]);
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst) begin
      state_q <= CLEAR_ON_RESET ? CLEAR : RUN;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign reg_a_value = a_q;
  assign reg_b_value = b_q;
  assign busy        = clearing;

endmodule

// File: tb/tb_regfile.sv
// Directed plus random stimulus for regfile, checked against an array model.
module tb_regfile;

  logic        cpu_clk;
  logic        cpu_rst;
  logic        reg_a_read;
  logic [3:0]  reg_a;
  logic        reg_b_read;
  logic [3:0]  reg_b;
  logic [15:0] reg_a_value;
  logic [15:0] reg_b_value;
  logic        wr_en;
  logic [3:0]  wr_reg;
  logic [15:0] wr_value;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic [15:0] m [16];
  logic [15:0] ea, eb;
  int          clear_left = 0;

  regfile dut (
    .cpu_clk    (cpu_clk),
    .cpu_rst    (cpu_rst),
    .reg_a_read (reg_a_read),
    .reg_a      (reg_a),
    .reg_b_read (reg_b_read),
    .reg_b      (reg_b),
    .reg_a_value(reg_a_value),
    .reg_b_value(reg_b_value),
    .wr_en      (wr_en),
    .wr_reg     (wr_reg),
    .wr_value   (wr_value),
    .busy       (busy)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, update the model at the edge, check 1ns later.
  task automatic step(input logic rst, input logic ra_en, input logic [3:0] ra,
                      input logic rb_en, input logic [3:0] rb,
                      input logic we, input logic [3:0] wr, input logic [15:0] wv);
    logic wok;
    @(negedge cpu_clk);
    cpu_rst = rst; reg_a_read = ra_en; reg_a = ra; reg_b_read = rb_en; reg_b = rb;
    wr_en = we; wr_reg = wr; wr_value = wv;
    @(posedge cpu_clk);
    if (!rst) begin
      ea = 16'h0; eb = 16'h0; clear_left = 16;
    end else if (clear_left > 0) begin
      if (ra_en) ea = 16'h0;
      if (rb_en) eb = 16'h0;
      m[16 - clear_left] = 16'h0;
      clear_left--;
    end else begin
      wok = we && (wr != 4'd0);
      if (ra_en) ea = (ra == 4'd0) ? 16'h0 : ((wok && wr == ra) ? wv : m[ra]);
      if (rb_en) eb = (rb == 4'd0) ? 16'h0 : ((wok && wr == rb) ? wv : m[rb]);
      if (wok) m[wr] = wv;
    end
    #1;
    $display("step rst=%0b a=%0b/%0d b=%0b/%0d wr=%0b/%0d/%h -> a=%h b=%h busy=%0b",
             rst, ra_en, ra, rb_en, rb, we, wr, wv, reg_a_value, reg_b_value, busy);
    chk("reg_a_value", {16'h0, reg_a_value}, {16'h0, ea});
    chk("reg_b_value", {16'h0, reg_b_value}, {16'h0, eb});
    chk("busy", {31'h0, busy}, {31'h0, (clear_left > 0)});
  endtask

  // Runs the clear sequence from reset release, writing r3 at cnt=2, and
  // checks that busy lasts exactly 16 edges.
  task automatic run_clear(input string tag);
    int n;
    n = 0;
    do begin
      step(1'b1, (n == 2), 4'd3, 1'b0, 4'd0, (n == 2), 4'd3, 16'hAAAA);
      n++;
    end while (busy && n < 40);
    chk(tag, n, 16);
  endtask

  task automatic read_all_zero();
    for (int i = 1; i < 16; i++) begin
      step(1'b1, 1'b1, 4'(i), 1'b1, 4'(16 - i), 1'b0, 4'd0, 16'h0);
      chk("cleared_reg", {16'h0, reg_a_value}, 32'h0);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) m[i] = 'x;
    ea = 'x; eb = 'x;
    cpu_rst = 1'b0; reg_a_read = 1'b0; reg_a = '0; reg_b_read = 1'b0; reg_b = '0;
    wr_en = 1'b0; wr_reg = '0; wr_value = '0;

    // Reset state, with a write attempted in the reset cycle.
    step(1'b0, 1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 4'd6, 16'h5555);
    step(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 16'h0);

    run_clear("busy_len");
    read_all_zero();

    // Write then read on port A only; port B holds.
    step(1'b1, 1'b1, 4'd2, 1'b1, 4'd9, 1'b1, 4'd9, 16'h0777);
    step(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd5, 16'hBEEF);
    step(1'b1, 1'b1, 4'd5, 1'b0, 4'd0, 1'b0, 4'd0, 16'h0);
    chk("r5_read", {16'h0, reg_a_value}, 32'hBEEF);
    chk("b_hold", {16'h0, reg_b_value}, 32'h0777);

    // Same-cycle bypass on both ports.
    step(1'b1, 1'b1, 4'd7, 1'b1, 4'd7, 1'b1, 4'd7, 16'h1234);
    chk("bypass_a", {16'h0, reg_a_value}, 32'h1234);
    chk("bypass_b", {16'h0, reg_b_value}, 32'h1234);

    // r0 is hard-wired to zero.
    step(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd0, 16'hFFFF);
    step(1'b1, 1'b1, 4'd0, 1'b1, 4'd0, 1'b0, 4'd0, 16'h0);
    chk("r0_read", {16'h0, reg_a_value}, 32'h0);
    step(1'b1, 1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 4'd0, 16'hFFFF);
    chk("r0_bypass", {16'h0, reg_b_value}, 32'h0);

    for (int i = 0; i < 300; i++) begin
      step(1'b1, 1'($urandom_range(1)), 4'($urandom_range(15)),
           1'($urandom_range(1)), 4'($urandom_range(15)),
           1'($urandom_range(1)), 4'($urandom_range(15)), 16'($urandom));
    end

    // Reset mid-clear at cnt=9 restarts the full sequence.
    step(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 16'h0);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 16'h0);
    step(1'b0, 1'b1, 4'd4, 1'b1, 4'd8, 1'b1, 4'd4, 16'h4444);
    chk("midclr_rst_a", {16'h0, reg_a_value}, 32'h0);
    run_clear("busy_len_restart");
    read_all_zero();

    for (int i = 0; i < 100; i++) begin
      step(1'b1, 1'($urandom_range(1)), 4'($urandom_range(15)),
           1'($urandom_range(1)), 4'($urandom_range(15)),
           1'($urandom_range(1)), 4'($urandom_range(15)), 16'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 SHALL have parameter R0_ZERO, default 1, meaning register 0 reads as 0 and ignores writes.
REQ-002 SHALL have parameter CLEAR_ON_RESET, default 1, meaning storage is zeroed by the clear sequencer after reset.
REQ-003 SHALL have port cpu_clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port cpu_rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port reg_a_read  input  1  port-A read request from the read stage.
REQ-006 SHALL have port reg_a  input  4  port-A register index.
REQ-007 SHALL have port reg_b_read  input  1  port-B read request.
REQ-008 SHALL have port reg_b  input  4  port-B register index.
REQ-009 SHALL have port reg_a_value  output  16  port-A read data.
REQ-010 SHALL have port reg_b_value  output  16  port-B read data.
REQ-011 SHALL have port wr_en  input  1  write-back request.
REQ-012 SHALL have port wr_reg  input  4  write-back register index.
REQ-013 SHALL have port wr_value  input  16  write-back data.
REQ-014 SHALL have port busy  output  1  high while the clear sequence runs.

Function
REQ-015 Storage SHALL be 16 x 16-bit, with one write port and two independent read ports.
REQ-016 Read latency SHALL be one cycle: reg_x_read high at edge N makes reg_x_value valid after edge N and until the next accepted read on that port.
REQ-017 When reg_x_read is low, reg_x_value SHALL hold its previous value.
REQ-018 Write SHALL commit at the edge where wr_en is high; the value is visible to reads issued in later cycles.
REQ-019 Bypass: a read in the same cycle as a write to the same index SHALL return wr_value, not the stale contents.
REQ-020 With R0_ZERO=1, writes to index 0 SHALL be discarded, and reads of index 0 SHALL return 0, including under bypass.
REQ-021 Both ports reading the same index SHALL return identical data.
REQ-022 The FSM SHALL have states CLEAR and RUN: CLEAR writes 0 to index cnt, with cnt running 0..15 at one per cycle; after cnt=15 the FSM goes to RUN; busy=1 exactly while in CLEAR (16 cycles).
REQ-023 In CLEAR, external writes SHALL be ignored and reads SHALL return 0.
REQ-024 With CLEAR_ON_RESET=0, reset SHALL go directly to RUN, busy SHALL stay 0, and storage contents SHALL be undefined.
REQ-025 cnt SHALL be a 4-bit counter whose terminal condition is cnt==15; the counter SHALL NOT wrap into a second pass.

Reset
REQ-026 While cpu_rst=0 at an edge: reg_a_value=0, reg_b_value=0, cnt=0, and the state becomes CLEAR (or RUN if CLEAR_ON_RESET=0); busy=1 in the following cycle.
REQ-027 Reset asserted mid-CLEAR or mid-RUN SHALL restart the sequence from cnt=0; a write in the reset cycle SHALL be discarded.
REQ-028 The storage array SHALL NOT be reset directly; only the sequencer SHALL zero it, so the array remains RAM-inferable.

Structure
REQ-029 Shared package SHALL hold REG_W=16, REG_CNT=16, REG_IDX_W=4, and the regfile_state_t enum {CLEAR, RUN}.
REQ-030 The block SHALL be a single module with no sub-module; the storage array SHALL be written only from one always block (single write port, muxing sequencer and wr_*).

Verification
REQ-031 Release reset -> busy=1 for exactly 16 cycles; reads of r1..r15 afterwards -> 0x0000.
REQ-032 Write r5=0xBEEF, next cycle read A r5 -> reg_a_value=0xBEEF one cycle later; read B idle -> reg_b_value unchanged.
REQ-033 Same cycle: wr r7=0x1234, read A r7, read B r7 -> both values 0x1234 next cycle.
REQ-034 Write r0=0xFFFF, then read r0 on both ports -> 0x0000; same-cycle bypass on r0 -> 0x0000.
REQ-035 Write r3=0xAAAA during CLEAR at cnt=2 -> after busy falls, r3 reads 0x0000.
REQ-036 Reset asserted at cnt=9 -> outputs 0, busy stays high for a full 16 cycles after release.
